// File: rtl/ofs_fim_pcie_ss_txcrdt_pkg.sv
// Shared TX credit definitions: credit-type index, request type, data-credit math.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package ofs_fim_pcie_ss_txcrdt_pkg;

  // Credit-type index carried in txcrdt_tdata[18:16]; same encoding as the RX credit path.
  // 3'b011 and 3'b111 are reserved and carry no credit.
  typedef enum logic [2:0] {
    CRDT_PH   = 3'b000,
    CRDT_NPH  = 3'b001,
    CRDT_CPLH = 3'b010,
    CRDT_PD   = 3'b100,
    CRDT_NPD  = 3'b101,
    CRDT_CPLD = 3'b110
  } crdt_idx_e;

  // Per-requester TLP class; 2'b11 is illegal and can never be granted.
  typedef enum logic [1:0] {
    REQ_POSTED    = 2'b00,
    REQ_NONPOSTED = 2'b01,
    REQ_CPL       = 2'b10,
    REQ_ILLEGAL   = 2'b11
  } req_type_e;

  localparam int LEN_W     = 10;  // PCIe length field, DW units, 0 encodes 1024
  localparam int DCRDT_W   = 9;   // data credits per TLP, max 256
  localparam int TXCRDT_DW = 19;  // {idx[2:0], limit[15:0]}

  // Data credits (16 B units) needed by one TLP: ceil(len_dw / 4), zero without payload.
  function automatic logic [DCRDT_W-1:0] data_credits(input logic has_data,
                                                      input logic [LEN_W-1:0] len);
    logic [LEN_W:0] len_eff;
    len_eff = (len == '0) ? 11'd1024 : {1'b0, len};
    return has_data ? DCRDT_W'((len_eff + 11'd3) >> 2) : '0;
  endfunction

endpackage

// File: rtl/ofs_fim_pcie_ss_txcrdt_rr_pick.sv
// Rotating-priority one-hot picker: first set bit of eligible starting at ptr, wrapping.
// Latency: purely combinational.
// Backpressure: none; the caller decides what eligible means.
module ofs_fim_pcie_ss_txcrdt_rr_pick #(
  parameter int N     = 4,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     eligible,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     winner,
  output logic             valid
);

  int idx;

  // Walk candidates ptr, ptr+1, ... mod N and keep the first eligible one.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!valid && eligible[idx]) begin
        winner[idx] = 1'b1;
        valid       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ofs_fim_pcie_ss_txcrdt_arb.sv
// Grants NUM_REQ TLP sources against the PCIe SS TX credit pool (limit - consumed per type).
// Latency: grant and hol_blocked are registered, one cycle after the request is eligible.
// Backpressure: a request that does not fit stalls (strict) or is skipped when
//   OFS_FIM_PCIE_SS_TXCRDT_BYPASS_EN is defined; hol_blocked reports the refusal.
module ofs_fim_pcie_ss_txcrdt_arb
  import ofs_fim_pcie_ss_txcrdt_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int CRDT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  txcrdt_tvalid,
  input  logic [TXCRDT_DW-1:0]  txcrdt_tdata,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [2*NUM_REQ-1:0]  req_type,
  input  logic [NUM_REQ-1:0]    req_has_data,
  input  logic [10*NUM_REQ-1:0] req_len,
  output logic [NUM_REQ-1:0]    grant,
  output logic                  hol_blocked
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // Index 0/1/2 = posted / non-posted / completion, matching req_type_e values.
  logic [2:0][CRDT_W-1:0] lim_h, lim_d, con_h, con_d;
  logic [2:0][CRDT_W-1:0] avail_h, avail_d;

  logic [PTR_W-1:0]               ptr;
  logic [NUM_REQ-1:0]             mask, fits, first_oh, win_oh;
  logic                           first_vld, hol_nxt;
  logic [NUM_REQ-1:0][DCRDT_W-1:0] need;
  logic [PTR_W-1:0]               win_idx;
  req_type_e                      win_typ;
  logic [DCRDT_W-1:0]             win_need;
  crdt_idx_e                      upd_idx;
  logic [CRDT_W-1:0]              upd_val;

  assign upd_idx = crdt_idx_e'(txcrdt_tdata[18:16]);
  assign upd_val = CRDT_W'(txcrdt_tdata[15:0]);

  // Remaining credit per type; modulo arithmetic makes counter wrap harmless.
  always_comb begin
    avail_h = '0;
    avail_d = '0;
    for (int t = 0; t < 3; t++) begin
      avail_h[t] = lim_h[t] - con_h[t];
      avail_d[t] = lim_d[t] - con_d[t];
    end
  end

  // Per-requester credit need and fit; a requester granted last cycle is masked so a
  // still-high req_valid cannot be granted twice for one TLP.
  always_comb begin
    mask = req_valid & ~grant;
    fits = '0;
    need = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      need[i] = data_credits(req_has_data[i], req_len[10*i +: 10]);
      unique case (req_type_e'(req_type[2*i +: 2]))
        REQ_POSTED:    fits[i] = (avail_h[0] != '0) && (avail_d[0] >= CRDT_W'(need[i]));
        REQ_NONPOSTED: fits[i] = (avail_h[1] != '0) && (avail_d[1] >= CRDT_W'(need[i]));
        REQ_CPL:       fits[i] = (avail_h[2] != '0) && (avail_d[2] >= CRDT_W'(need[i]));
        default:       fits[i] = 1'b0;
      endcase
    end
  end

  // First valid requester in rotating order; it defines head-of-line blocking in both builds.
  ofs_fim_pcie_ss_txcrdt_rr_pick #(
    .N     (NUM_REQ),
    .PTR_W (PTR_W)
  ) u_pick_first (
    .eligible (mask),
    .ptr      (ptr),
    .winner   (first_oh),
    .valid    (first_vld)
  );

`ifdef OFS_FIM_PCIE_SS_TXCRDT_BYPASS_EN
  logic [NUM_REQ-1:0] fit_oh;
  logic               fit_vld;

  // Bypass: credit-starved requesters are skipped, the first one that fits wins.
  ofs_fim_pcie_ss_txcrdt_rr_pick #(
    .N     (NUM_REQ),
    .PTR_W (PTR_W)
  ) u_pick_fit (
    .eligible (mask & fits),
    .ptr      (ptr),
    .winner   (fit_oh),
    .valid    (fit_vld)
  );

  // Winner is the first fitting requester, if any.
  always_comb begin
    win_oh = fit_vld ? fit_oh : '0;
  end
`else
  // Strict: the head requester wins only if it fits, otherwise nobody is granted.
  always_comb begin
    win_oh = (first_vld && (|(first_oh & fits))) ? first_oh : '0;
  end
`endif

  assign hol_nxt = first_vld && !(|(first_oh & fits));

  // Decode the one-hot winner into index, type and data need for the state updates.
  always_comb begin
    win_idx  = '0;
    win_typ  = REQ_POSTED;
    win_need = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_oh[i]) begin
        win_idx  = PTR_W'(i);
        win_typ  = req_type_e'(req_type[2*i +: 2]);
        win_need = need[i];
      end
    end
  end

  // Grant pulse, blocking flag and rotating pointer; ptr only moves on a grant.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      grant       <= '0;
      hol_blocked <= 1'b0;
      ptr         <= '0;
    end else begin
      grant       <= win_oh;
      hol_blocked <= hol_nxt;
      if (|win_oh) begin
        ptr <= (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + PTR_W'(1);
      end
    end
  end

  // Credit state: consume on grant, replace limits on update; they never share a register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lim_h <= '0;
      lim_d <= '0;
      con_h <= '0;
      con_d <= '0;
    end else begin
      if (|win_oh) begin
        unique case (win_typ)
          REQ_POSTED: begin
            con_h[0] <= con_h[0] + CRDT_W'(1);
            con_d[0] <= con_d[0] + CRDT_W'(win_need);
          end
          REQ_NONPOSTED: begin
            con_h[1] <= con_h[1] + CRDT_W'(1);
            con_d[1] <= con_d[1] + CRDT_W'(win_need);
          end
          REQ_CPL: begin
            con_h[2] <= con_h[2] + CRDT_W'(1);
            con_d[2] <= con_d[2] + CRDT_W'(win_need);
          end
          default: ;
        endcase
      end
      if (txcrdt_tvalid) begin
        case (upd_idx)
          CRDT_PH:   lim_h[0] <= upd_val;
          CRDT_NPH:  lim_h[1] <= upd_val;
          CRDT_CPLH: lim_h[2] <= upd_val;
          CRDT_PD:   lim_d[0] <= upd_val;
          CRDT_NPD:  lim_d[1] <= upd_val;
          CRDT_CPLD: lim_d[2] <= upd_val;
          default:   ;
        endcase
      end
    end
  end

endmodule

// File: doc/ofs_fim_pcie_ss_txcrdt_arb.md
# ofs_fim_pcie_ss_txcrdt_arb

Shares the PCIe SS TX credit pool between NUM_REQ TLP sources inside the OFS clock domain. It tracks the SS-advertised cumulative credit limits (PH/PD/NPH/NPD/CPLH/CPLD) and its own consumed counters. A requester is granted only when its whole TLP fits the remaining credits. It sits ahead of the TX AXI-S mux. The credit-limit stream is already synchronized to `clk` upstream.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- CRDT_W, 16, width of limit/consumed counters (modulo arithmetic)
- clk  in  1  OFS clock
- rst_n  in  1  synchronous, active-low reset
- txcrdt_tvalid  in  1  credit-limit update strobe
- txcrdt_tdata  in  19  {idx[2:0], limit[15:0]}; idx PH=000, NPH=001, CPLH=010, PD=100, NPD=101, CPLD=110; 011/111 reserved
- req_valid  in  NUM_REQ  request pending; held until granted
- req_type  in  2*NUM_REQ  per requester: 00 posted, 01 non-posted, 10 completion, 11 illegal
- req_has_data  in  NUM_REQ  TLP carries payload
- req_len  in  10*NUM_REQ  payload length in DW, PCIe encoding (0 = 1024)
- grant  out  NUM_REQ  one-hot, one-cycle pulse
- hol_blocked  out  1  a valid winner was refused for lack of credit this cycle

## Operation
- Per type: limit register (reset 0) and consumed register (reset 0). avail = (limit - consumed) mod 2^CRDT_W.
- Before the first limit update for a type, avail = 0, so requests of that type stall.
- Limit update: on txcrdt_tvalid, limit[idx] <= count. The value is replaced, not accumulated. Reserved idx is ignored.
- Need per request:
  - header need = 1 of the matching type.
  - data need = (len_eff + 3) >> 2 when req_has_data, else 0.
  - len_eff = 1024 when req_len = 0; maximum data need is 256.
- A request fits when avail_h >= 1 and avail_d >= data need.
- req_type 11 never fits and never grants.
- Arbitration is rotating priority.
  - The pointer resets to 0.
  - The candidate order is ptr, ptr+1, … modulo NUM_REQ.
  - After a grant to i, ptr <= (i+1) mod NUM_REQ.
  - With no grant, ptr holds.
- On a grant to i:
  - consumed_h[type_i] += 1.
  - consumed_d[type_i] += data need.
  - Both updates are modulo 2^CRDT_W.
- A limit update and a consume on the same cycle both apply. They touch different registers.
- Requester i is masked from arbitration in the cycle its grant is high. This prevents a double grant from a still-high req_valid.

## Timing
- Arbitration is combinational on registered state and the current req_* inputs.
- grant and the consumed updates are registered together. grant rises the cycle after the winning request is first eligible.
- Throughput:
  - One grant per cycle maximum.
  - Different requesters can be granted on consecutive cycles.
  - The same requester can be granted at most every other cycle.
- Requester handshake:
  - Sample grant[i] on the clock edge.
  - In the following cycle, drop req_valid[i] or present the next TLP's fields.
  - req_type, req_has_data and req_len must stay stable while req_valid is high and ungranted.
- A limit update at edge t is visible to arbitration in cycle t+1.
- Reset state: grant=0, hol_blocked=0, ptr=0, all limits and consumed =0. Reset mid-operation discards pending grants and all credit state.

## Configuration
- OFS_FIM_PCIE_SS_TXCRDT_BYPASS_EN defined:
  - The winner is the first valid requester in rotating order whose request fits.
  - A credit-starved requester does not block the others.
  - hol_blocked = 1 when the first valid requester in order did not fit, even if a later one was granted.
- Not defined (strict):
  - The winner is the first valid requester in rotating order.
  - If it does not fit, no grant is issued, ptr holds, and hol_blocked = 1.
  - This ordering is guaranteed starvation-free.

## Structure
- Shared package ofs_fim_pcie_ss_txcrdt_pkg holds:
  - the credit-type index enum (same 3-bit encoding as the RX credit path);
  - the req_type encoding;
  - a function returning data credits from {has_data, len}.
- One sub-module: ofs_fim_pcie_ss_txcrdt_rr_pick. It is a rotating-priority one-hot picker with inputs {eligible mask, ptr} and outputs {one-hot winner, valid}.
  - The parent drives the eligible mask as valid & fits (bypass) or valid only (strict), then checks fit on the winner.

## Test plan
- Reset, no limit updates; req_valid[0]=1, posted, len=4 → no grant for 100 cycles, hol_blocked=1.
- Limits PH=2, PD=8; req 0 and 1 both posted, len=16 (4 credits) → grant[0] then grant[1] on consecutive cycles. consumed PH=2, PD=8. A third posted request stalls until the PH limit is raised to 3.
- len=0 with has_data, CPLH=1, CPLD=255 → no grant. Raise CPLD to 256 → grant, consumed CPLD=256.
- Wrap: limit PH=0x0001 and consumed PH=0xFFFF (seeded by 0xFFFF grants, or reset with limit sequence) → avail=2, two grants issued, third blocked.
- Starvation, all 4 requesters non-posted with ample credit → grants rotate 0,1,2,3,0 with no repeats inside a rotation.
- Req 0 needs PD=16 with only 4 available, req 1 non-posted fits → bypass build: grant[1], hol_blocked=1. Strict build: no grant until PD is raised.
